// File: rtl/fir_param_axis.sv
// rtl/fir_param_axis.sv - parametrised FIR engine, AXI-Lite config, AXI-Stream samples in/out
// One MAC per cycle over an internal circular sample history; coefficients live in registers.
module fir_param_axis #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pACC_WIDTH  = 48,
    parameter int pNUM_TAPS   = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   ss_tvalid,
    output logic                   ss_tready,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
);
    localparam int IW = (pNUM_TAPS > 1) ? $clog2(pNUM_TAPS) : 1;
    localparam int PW = 2 * pDATA_WIDTH;
    localparam logic [pADDR_WIDTH-1:0] A_CTRL    = '0;
    localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] A_SHIFT   = pADDR_WIDTH'(20);
    localparam logic [pADDR_WIDTH-1:0] A_COEF_LO = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] A_COEF_HI = pADDR_WIDTH'(32 + 4 * pNUM_TAPS);
    localparam logic [IW-1:0]          LAST_TAP  = IW'(pNUM_TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_MAC, S_OUT} state_t;

    state_t                        r_state;
    logic signed [pDATA_WIDTH-1:0] r_coef [pNUM_TAPS];
    logic signed [pDATA_WIDTH-1:0] r_hist [pNUM_TAPS];
    logic [pDATA_WIDTH-1:0]        r_len;
    logic [pDATA_WIDTH-1:0]        r_count;
    logic [5:0]                    r_shift;
    logic                          r_ap_done;
    logic                          r_ap_idle;
    logic                          r_err;
    logic [IW-1:0]                 r_head;
    logic [IW-1:0]                 r_tap;
    logic [IW-1:0]                 r_xidx;
    logic signed [pACC_WIDTH-1:0]  r_acc;
    logic                          r_awready;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_rd_ctrl;
    logic [pDATA_WIDTH-1:0]        r_rdata;
    logic                          r_ss_tready;
    logic                          r_sm_tvalid;
    logic [pDATA_WIDTH-1:0]        r_sm_tdata;
    logic                          r_sm_tlast;

    logic                          w_wr_fire;
    logic                          w_cfg_wr;
    logic                          w_start;
    logic                          w_rd_clear;
    logic [pDATA_WIDTH-1:0]        w_rd_mux;
    logic [pDATA_WIDTH-1:0]        w_count_nxt;
    logic signed [PW-1:0]          w_prod;
    logic signed [pACC_WIDTH-1:0]  w_prod_acc;
    logic signed [pACC_WIDTH-1:0]  w_shifted;

    function automatic logic coef_hit(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_COEF_LO) && (a < A_COEF_HI) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IW-1:0] coef_idx(input logic [pADDR_WIDTH-1:0] a);
        logic [pADDR_WIDTH-1:0] ofs;
        ofs = a - A_COEF_LO;
        return IW'(ofs >> 2);
    endfunction

    assign awready   = r_awready;
    assign wready    = r_awready;
    assign arready   = r_arready;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign ss_tready = r_ss_tready;
    assign sm_tvalid = r_sm_tvalid;
    assign sm_tdata  = r_sm_tdata;
    assign sm_tlast  = r_sm_tlast;

    assign w_wr_fire   = r_awready && awvalid && wvalid;
    assign w_cfg_wr    = w_wr_fire && r_ap_idle;
    assign w_start     = w_cfg_wr && (awaddr == A_CTRL) && wdata[0];
    assign w_rd_clear  = r_rvalid && rready && r_rd_ctrl;
    assign w_count_nxt = r_count + pDATA_WIDTH'(1);
    assign w_prod      = PW'(r_coef[r_tap]) * PW'(r_hist[r_xidx]);
    assign w_prod_acc  = pACC_WIDTH'(w_prod);
    assign w_shifted   = r_acc >>> r_shift;

    always_comb begin
        w_rd_mux = '0;
        if (araddr == A_CTRL)
            w_rd_mux = pDATA_WIDTH'({r_err, r_ap_idle, r_ap_done, 1'b0});
        else if (araddr == A_LEN)
            w_rd_mux = r_len;
        else if (araddr == A_SHIFT)
            w_rd_mux = pDATA_WIDTH'(r_shift);
        else if (coef_hit(araddr))
            w_rd_mux = r_coef[coef_idx(araddr)];
    end

    // AXI-Lite handshakes: address and data are taken together on the single ready pulse
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rd_ctrl <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_awready <= awvalid && wvalid && !r_awready;
            r_arready <= arvalid && !r_rvalid && !r_arready;
            if (r_arready && arvalid) begin
                r_rvalid  <= 1'b1;
                r_rdata   <= w_rd_mux;
                r_rd_ctrl <= (araddr == A_CTRL);
            end else if (r_rvalid && rready) begin
                r_rvalid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_len   <= '0;
            r_shift <= '0;
            for (int i = 0; i < pNUM_TAPS; i++) r_coef[i] <= '0;
        end else if (w_cfg_wr) begin
            if (awaddr == A_LEN)
                r_len <= wdata;
            else if (awaddr == A_SHIFT)
                r_shift <= wdata[5:0];
            else if (coef_hit(awaddr))
                r_coef[coef_idx(awaddr)] <= wdata;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state     <= S_IDLE;
            r_ap_done   <= 1'b0;
            r_ap_idle   <= 1'b1;
            r_err       <= 1'b0;
            r_count     <= '0;
            r_head      <= '0;
            r_tap       <= '0;
            r_xidx      <= '0;
            r_acc       <= '0;
            r_ss_tready <= 1'b0;
            r_sm_tvalid <= 1'b0;
            r_sm_tdata  <= '0;
            r_sm_tlast  <= 1'b0;
            for (int i = 0; i < pNUM_TAPS; i++) r_hist[i] <= '0;
        end else begin
            // status clear from a ctrl read; any completion on the same edge overrides it below
            if (w_rd_clear) begin
                r_ap_done <= 1'b0;
                r_err     <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < pNUM_TAPS; i++) r_hist[i] <= '0;
                        r_count     <= '0;
                        r_head      <= '0;
                        r_ap_done   <= 1'b0;
                        r_err       <= 1'b0;
                        r_ap_idle   <= 1'b0;
                        r_ss_tready <= (r_len != '0);
                        r_state     <= S_WAIT_IN;
                    end
                end
                S_WAIT_IN: begin
                    if (r_len == '0) begin
                        r_ap_done <= 1'b1;
                        r_ap_idle <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (ss_tvalid && r_ss_tready) begin
                        r_hist[r_head] <= ss_tdata;
                        r_xidx         <= r_head;
                        r_head         <= (r_head == LAST_TAP) ? '0 : r_head + IW'(1);
                        r_count        <= w_count_nxt;
                        r_acc          <= '0;
                        r_tap          <= '0;
                        r_ss_tready    <= 1'b0;
                        if (ss_tlast != (w_count_nxt == r_len))
                            r_err <= 1'b1;
                        r_state        <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc  <= r_acc + w_prod_acc;
                    r_xidx <= (r_xidx == '0) ? LAST_TAP : r_xidx - IW'(1);
                    r_tap  <= r_tap + IW'(1);
                    if (r_tap == LAST_TAP)
                        r_state <= S_OUT;
                end
                S_OUT: begin
                    if (!r_sm_tvalid) begin
                        r_sm_tvalid <= 1'b1;
                        r_sm_tdata  <= pDATA_WIDTH'(w_shifted);
                        r_sm_tlast  <= (r_count == r_len);
                    end else if (sm_tready) begin
                        r_sm_tvalid <= 1'b0;
                        r_sm_tlast  <= 1'b0;
                        if (r_sm_tlast) begin
                            r_ap_done <= 1'b1;
                            r_ap_idle <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_ss_tready <= 1'b1;
                            r_state     <= S_WAIT_IN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_param_axis.sv
// tb/tb_fir_param_axis.sv - scoreboard bench for fir_param_axis
`timescale 1ns/1ps
module tb_fir_param_axis;
    localparam int AW = 12, DW = 32, ACCW = 48, NT = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;
    logic          ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [DW-1:0] ss_tdata, sm_tdata;

    always #5 clk = ~clk;

    fir_param_axis #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pACC_WIDTH(ACCW), .pNUM_TAPS(NT)) dut (
        .axis_clk(clk), .axis_rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    typedef struct { logic [DW-1:0] data; logic last; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp; } reg_vec_t;

    int       total = 0;
    int       bad = 0;
    int       n_out = 0;
    bit       mon_en = 1'b0;
    bit       bp = 1'b0;
    exp_t     q_exp[$];
    exp_t     mon_e;
    longint   m_coef[NT];
    int       m_shift = 0;
    longint   frame_x[$];
    int       coef_init[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    reg_vec_t vec[16];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_out();
        longint acc;
        int n;
        acc = 0;
        n = frame_x.size() - 1;
        for (int k = 0; k < NT; k++)
            if (n - k >= 0) acc += m_coef[k] * frame_x[n - k];
        acc = (acc <<< (64 - ACCW)) >>> (64 - ACCW);
        acc = acc >>> m_shift;
        return acc[DW-1:0];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            sm_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (sm_tvalid) check("ss_tready_while_out", 32'(ss_tready), 32'(0));
            if (sm_tvalid && sm_tready) begin
                n_out++;
                if (q_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got 0x%0h want none", sm_tdata);
                end else begin
                    mon_e = q_exp.pop_front();
                    check("sm_tdata", sm_tdata, mon_e.data);
                    check("sm_tlast", 32'(sm_tlast), 32'(mon_e.last));
                end
            end
        end
    end

    task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        if (!awready) begin total++; bad++; $display("FAIL axil_write_timeout: got no awready want awready"); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axil_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int t;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 100) begin @(negedge clk); t++; end
        if (!rvalid) begin total++; bad++; $display("FAIL axil_read_timeout: got no rvalid want rvalid"); end
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        axil_read(a, d);
        check(name, d, exp);
    endtask

    task automatic check_reset_outs();
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_rdata", rdata, 0);
        check("rst_ss_tready", 32'(ss_tready), 0);
        check("rst_sm_tvalid", 32'(sm_tvalid), 0);
        check("rst_sm_tdata", sm_tdata, 0);
        check("rst_sm_tlast", 32'(sm_tlast), 0);
    endtask

    task automatic start_frame(input int len);
        axil_write(12'h010, DW'(len));
        frame_x.delete();
        axil_write(12'h000, 32'h1);
    endtask

    // kind 0: impulse, kind 1: triangle wave
    task automatic drive_frame(input int len, input int kind, input int tlast_at, input int n_drive, input int gap_max);
        int     t;
        int     p;
        longint x;
        exp_t   e;
        for (int i = 0; i < n_drive; i++) begin
            p = i % 64;
            x = (kind == 0) ? ((i == 0) ? 1 : 0) : (longint'((p < 32) ? p : 64 - p) * 1000 - 16000);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            @(negedge clk);
            frame_x.push_back(x);
            e.data = model_out();
            e.last = (i == len - 1);
            q_exp.push_back(e);
            ss_tdata = x[DW-1:0]; ss_tlast = (i + 1 == tlast_at); ss_tvalid = 1'b1;
            t = 0;
            while (!ss_tready && t < 2000) begin @(negedge clk); t++; end
            if (!ss_tready) begin
                total++; bad++;
                $display("FAIL ss_tready_timeout: got no ss_tready want ss_tready at sample %0d", i);
                ss_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            ss_tvalid = 1'b0; ss_tlast = 1'b0;
        end
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (q_exp.size() != 0 && t < bound) begin @(negedge clk); t++; end
        if (q_exp.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q_exp.size());
            q_exp.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_coefs();
        for (int k = 0; k < NT; k++) begin
            axil_write(AW'(32 + 4 * k), DW'(coef_init[k]));
            m_coef[k] = coef_init[k];
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n0;
        exp_t e;
        rst = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; awaddr = '0; araddr = '0; wdata = '0;
        ss_tvalid = 0; ss_tdata = '0; ss_tlast = 0; sm_tready = 0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        mon_en = 1'b1;
        check_read("ctrl_after_reset", 12'h000, 32'h4);
        check_read("coef0_after_reset", 12'h020, 32'h0);

        for (int k = 0; k < NT; k++) vec[k] = '{AW'(32 + 4 * k), DW'(coef_init[k]), DW'(coef_init[k])};
        vec[11] = '{12'h010, 32'd600,  32'd600};
        vec[12] = '{12'h014, 32'h7f,   32'h3f};
        vec[13] = '{12'h04c, 32'h5,    32'h0};
        vec[14] = '{12'h004, 32'h55,   32'h0};
        vec[15] = '{12'h022, 32'h7,    32'h0};
        for (int i = 0; i < 16; i++) axil_write(vec[i].addr, vec[i].wdata);
        for (int i = 0; i < 16; i++) check_read($sformatf("reg_%0h", vec[i].addr), vec[i].addr, vec[i].exp);
        for (int k = 0; k < NT; k++) m_coef[k] = coef_init[k];
        check_read("ctrl_idle", 12'h000, 32'h4);
        axil_write(12'h014, 0); m_shift = 0;

        start_frame(16);
        drive_frame(16, 0, 16, 16, 0);
        wait_drain(2000);
        check_read("ctrl_done_impulse", 12'h000, 32'h6);
        check_read("ctrl_clear_impulse", 12'h000, 32'h4);

        start_frame(1);
        @(negedge clk);
        frame_x.push_back(5);
        e.data = model_out(); e.last = 1'b1; q_exp.push_back(e);
        ss_tdata = 32'd5; ss_tlast = 1'b1; ss_tvalid = 1'b1;
        cyc = 0;
        while (!ss_tready && cyc < 100) begin @(negedge clk); cyc++; end
        @(posedge clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
        cyc = 0;
        while (!sm_tvalid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("latency", cyc, NT + 1);
        wait_drain(200);
        check_read("ctrl_len1", 12'h000, 32'h6);

        axil_write(12'h034, 64); m_coef[5] = 64;
        axil_write(12'h014, 3);  m_shift = 3;
        start_frame(16);
        drive_frame(16, 0, 16, 16, 0);
        wait_drain(2000);
        axil_write(12'h034, 63); m_coef[5] = 63;
        axil_write(12'h014, 1);  m_shift = 1;
        start_frame(16);
        drive_frame(16, 0, 16, 16, 0);
        wait_drain(2000);
        axil_write(12'h014, 0); m_shift = 0;

        n0 = n_out;
        bp = 1'b1;
        start_frame(600);
        drive_frame(600, 1, 600, 600, 1);
        wait_drain(30000);
        bp = 1'b0;
        check("bp_output_count", n_out - n0, 600);
        check_read("ctrl_done_bp", 12'h000, 32'h6);

        start_frame(16);
        fork
            drive_frame(16, 1, 16, 16, 0);
            begin
                repeat (30) @(negedge clk);
                axil_write(12'h02c, 99);
                axil_write(12'h000, 32'h1);
                axil_write(12'h010, 3);
            end
        join
        wait_drain(2000);
        check_read("busy_coef3", 12'h02c, 32'd23);
        check_read("busy_len", 12'h010, 32'd16);
        check_read("busy_ctrl_done", 12'h000, 32'h6);
        check_read("busy_ctrl_clear", 12'h000, 32'h4);

        start_frame(16);
        drive_frame(16, 0, 10, 16, 0);
        wait_drain(2000);
        check_read("tlast_err", 12'h000, 32'he);
        check_read("tlast_err_clear", 12'h000, 32'h4);

        n0 = n_out;
        start_frame(0);
        repeat (20) @(negedge clk);
        check("len0_no_output", n_out - n0, 0);
        check_read("len0_ctrl", 12'h000, 32'h6);

        start_frame(16);
        drive_frame(16, 1, 16, 5, 0);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        q_exp.delete();
        @(negedge clk);
        check_reset_outs();
        rst = 1'b0;
        mon_en = 1'b1;
        check_read("ctrl_after_midreset", 12'h000, 32'h4);
        check_read("coef3_lost", 12'h02c, 32'h0);
        load_coefs();
        m_shift = 0;
        start_frame(16);
        drive_frame(16, 0, 16, 16, 0);
        wait_drain(2000);
        check_read("ctrl_done_after_reset", 12'h000, 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
